ifetch_prefetch: RTL and testbench

//  Instruction-fetch front end: generates sequential PCs, issues requests to a variable-latency

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/ifetch_fifo.sv | 72 +++++++
 rtl/ifetch_prefetch.sv | 142 ++++++++++++++
 tb/tb_ifetch_prefetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: machine widths, PC step, reset PC,
// fetch FSM states and the {pc, inst} queue entry.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst} with flush, registered pointers
// and a combinational read of the head slot.
module ifetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full queue can still accept when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= push_data;
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests to
// a variable-latency memory, prefetch queue, redirect flush with in-flight drop.
// Optional perf counters (stall_cycles, flush_count) when IFETCH_PERF_CNT_EN is defined.
module ifetch_prefetch
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_t   state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    fifo_head, push_entry;
  logic            fifo_push;
  logic            req_fire, rsp_drop;
  logic [CW:0]     credit_used;

  // Requests in flight plus queued entries may never exceed the queue size.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = (state_q != HOLD) && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = (drop_cnt_q != '0);
  assign fifo_push  = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (inst_ready),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? '0 : fifo_head.inst;
  assign inst_pc    = fifo_empty ? '0 : fifo_head.pc;

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    fetch_pc_d    = req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    if (imem_rsp_valid) begin
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
      else          rsp_pc_d   = rsp_pc_q + PC_STEP;
    end
    // Every request still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      drop_cnt_d = outstanding_d;
    end
    case (state_q)
      HOLD:    state_d = RUN;
      default: state_d = (drop_cnt_d != '0) ? FLUSH : RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= HOLD;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (inst_ready && !inst_valid && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (redirect_valid && (flush_count_q != '1))             flush_count_d  = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

  rsp_needs_credit: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding_q != '0));

  push_has_room: assert property (@(posedge clk) disable iff (!rst)
    fifo_push |-> (!fifo_full || (inst_ready && inst_valid)));

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch: in-order variable-latency memory model and
// a queue-based reference of what decode must receive after resets and redirects.
module tb_ifetch_prefetch;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  always #5 clk = ~clk;

  ifetch_prefetch #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        pend[$];      // accepted requests awaiting a memory response
  ent_t        mq[$];        // what decode should see, oldest first
  logic [31:0] post_del[$];  // pcs handed to decode after a triggered redirect

  int n_chk = 0;
  int n_fail = 0;

  int          cyc;
  bit          hold_m;
  logic [31:0] exp_req_pc, exp_del_pc;
  int          m_stall, m_flush, acc_total, first_iv;
  logic [31:0] first_del;
  bit          first_del_seen, prev_redir;

  int          p_rdy, p_irdy, p_redir, lat_lo, lat_hi;
  bit          trig_drop, trig_pc_en, redir_seen;
  logic [31:0] trig_pc, redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    post_del.delete();
    hold_m         = 1'b1;
    exp_req_pc     = 32'h0;
    exp_del_pc     = 32'h0;
    m_stall        = 0;
    m_flush        = 0;
    acc_total      = 0;
    first_iv       = -1;
    first_del_seen = 1'b0;
    first_del      = '0;
    prev_redir     = 1'b0;
    redir_seen     = 1'b0;
    trig_drop      = 1'b0;
    trig_pc_en     = 1'b0;
    cyc            = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_flush_count", flush_count, 32'd0);
`endif
    model_reset();
  endtask

  // One clock cycle: check outputs, drive inputs, advance the reference.
  task automatic step();
    bit          exp_rv, rsp, acc, deq, redir;
    int          lat, due;
    logic [31:0] tgt;
    req_t        r;
    @(negedge clk);

    check("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("inst_pc", inst_pc, mq[0].pc);
      check("inst", inst, mq[0].data);
    end
    if (prev_redir) check("post_redirect_valid", 32'(inst_valid), 32'd0);
    exp_rv = !hold_m && ((pend.size() + mq.size()) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid && exp_rv) check("req_addr", imem_req_addr, exp_req_pc);
`ifdef IFETCH_PERF_CNT_EN
    check("stall_cycles", stall_cycles, 32'(m_stall));
    check("flush_count", flush_count, 32'(m_flush));
`endif
    if (inst_valid && first_iv < 0) first_iv = cyc;

    imem_req_ready = ($urandom_range(99) < p_rdy);
    inst_ready     = ($urandom_range(99) < p_irdy);
    rsp            = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
    acc            = imem_req_valid && imem_req_ready;
    deq            = inst_valid && inst_ready;
    redir = !hold_m && (($urandom_range(99) < p_redir) ||
                        (trig_pc_en && inst_valid && inst_pc == trig_pc) ||
                        (trig_drop && acc && !rsp && pend.size() == 2));
    tgt = (trig_pc_en || trig_drop) ? redir_target : $urandom;
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom;

    if (inst_ready && !inst_valid) m_stall++;
    if (deq) begin
      check("deliver_order", inst_pc, exp_del_pc);
      exp_del_pc = exp_del_pc + 32'd4;
      if (redir_seen) post_del.push_back(inst_pc);
      if (!first_del_seen) begin
        first_del_seen = 1'b1;
        first_del      = inst_pc;
      end
      if (mq.size() != 0) void'(mq.pop_front());
    end
    if (rsp) begin
      r = pend.pop_front();
      if (!r.stale) mq.push_back('{pc: r.addr, data: mem_word(r.addr)});
    end
    if (acc) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (pend.size() != 0 && due < pend[$].due) due = pend[$].due;
      pend.push_back('{addr: exp_req_pc, due: due, stale: 1'b0});
      exp_req_pc = exp_req_pc + 32'd4;
      acc_total++;
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      mq.delete();
      exp_req_pc = {tgt[31:2], 2'b00};
      exp_del_pc = {tgt[31:2], 2'b00};
      m_flush++;
      if (trig_pc_en || trig_drop) begin
        redir_seen = 1'b1;
        post_del.delete();
        trig_pc_en = 1'b0;
        trig_drop  = 1'b0;
      end
    end
    prev_redir = redir;
    hold_m     = 1'b0;
    cyc++;
  endtask

  task automatic knobs(input int rdy, input int irdy, input int rd, input int lo, input int hi);
    p_rdy = rdy; p_irdy = irdy; p_redir = rd; lat_lo = lo; lat_hi = hi;
  endtask

  initial begin
    int n;
    knobs(100, 100, 0, 1, 1);
    model_reset();

    // Reset release, 1-cycle memory, decode always ready.
    do_reset(2);
    repeat (12) step();
    check("first_valid_cycle", 32'(first_iv), 32'd3);
    check("t1_accepts", 32'(acc_total), 32'd11);

    // Decode back-pressure: credit limit stops issue at DEPTH.
    do_reset(1);
    knobs(100, 0, 0, 1, 1);
    repeat (20) step();
    check("t2_accepts", 32'(acc_total), 32'd4);
    check("t2_head_pc", inst_pc, 32'd0);
    knobs(100, 100, 0, 1, 1);
    repeat (30) step();
    check("t2_first_deliver", first_del, 32'd0);

    // Latency 3, redirect with three requests to drop.
    do_reset(1);
    knobs(100, 100, 0, 3, 3);
    redir_target = 32'h40;
    trig_drop    = 1'b1;
    n = 0;
    while (!redir_seen && n < 50) begin step(); n++; end
    check("t3_redirect_fired", 32'(redir_seen), 32'd1);
    repeat (20) step();
    check("t3_post_count", 32'(post_del.size() >= 2), 32'd1);
    if (post_del.size() >= 2) begin
      check("t3_first_pc", post_del[0], 32'h40);
      check("t3_second_pc", post_del[1], 32'h44);
    end

    // Redirect to an unaligned target in the same cycle pc 8 is handed off.
    do_reset(1);
    knobs(100, 100, 0, 1, 1);
    redir_target = 32'h103;
    trig_pc      = 32'h8;
    trig_pc_en   = 1'b1;
    n = 0;
    while (!redir_seen && n < 50) begin step(); n++; end
    check("t4_redirect_fired", 32'(redir_seen), 32'd1);
    check("t4_pc8_delivered", exp_del_pc, 32'h100);
    repeat (15) step();
    check("t4_post_count", 32'(post_del.size() >= 2), 32'd1);
    if (post_del.size() >= 2) begin
      check("t4_first_pc", post_del[0], 32'h100);
      check("t4_second_pc", post_del[1], 32'h104);
    end

    // Fill the queue, then reset mid-stream.
    do_reset(1);
    knobs(100, 0, 0, 1, 1);
    n = 0;
    while (mq.size() != DEPTH && n < 30) begin step(); n++; end
    check("t5_queue_full", 32'(mq.size()), 32'(DEPTH));
    do_reset(1);
    knobs(100, 100, 0, 1, 1);
    repeat (10) step();
    check("t5_restart_pc", first_del, 32'h0);

    // Randomized traffic with redirects and variable latency.
    do_reset(1);
    knobs(70, 60, 4, 1, 4);
    repeat (1500) step();
    do_reset(1);
    knobs(100, 90, 8, 1, 2);
    repeat (1500) step();
    do_reset(2);
    knobs(50, 30, 3, 1, 5);
    repeat (1000) step();
`ifdef IFETCH_PERF_CNT_EN
    @(negedge clk);
    check("final_stall_cycles", stall_cycles, 32'(m_stall));
    check("final_flush_count", flush_count, 32'(m_flush));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
